// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle ARM controller and its datapath/memory.
// The controller takes the master side; the datapath takes the slave side.
interface multicycle_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        lmulFlag;
    logic        FpuWrite;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, lmulFlag, FpuWrite
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, lmulFlag, FpuWrite
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, instruction decoder and
// condition logic with an NZCV flags register.
module multicycle_controller #(
    parameter bit FPU_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master ctl
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, FPUEXEC, FPUWB
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  flags;
    logic [1:0]  op;
    logic [3:0]  cmd, cond, rd;
    logic        i_bit, s_bit, l_bit;
    logic        is_mul, is_lmul;
    logic [2:0]  alu_op;
    logic        nop, cmp, nz_only;
    logic        cond_ex, flag_we;

    assign op    = ctl.Instr[27:26];
    assign i_bit = ctl.Instr[25];
    assign cmd   = ctl.Instr[24:21];
    assign s_bit = ctl.Instr[20];
    assign l_bit = ctl.Instr[20];
    assign cond  = ctl.Instr[31:28];
    assign rd    = ctl.Instr[15:12];

    assign is_mul  = (op == 2'b00) && (ctl.Instr[7:4] == 4'b1001) && (ctl.Instr[27:22] == 6'b000000);
    assign is_lmul = (op == 2'b00) && (ctl.Instr[7:4] == 4'b1001) && (ctl.Instr[27:23] == 5'b00001);

    // Data-processing decode; multiplies take precedence over the cmd field.
    always_comb begin
        alu_op  = 3'b000;
        nop     = 1'b0;
        cmp     = 1'b0;
        nz_only = 1'b1;
        if (is_mul) begin
            alu_op = 3'b100;
        end else if (is_lmul) begin
            alu_op = ctl.Instr[22] ? 3'b110 : 3'b101;
        end else begin
            unique case (cmd)
                4'b0100: begin alu_op = 3'b000; nz_only = 1'b0; end
                4'b0010: begin alu_op = 3'b001; nz_only = 1'b0; end
                4'b0000: alu_op = 3'b010;
                4'b1100: alu_op = 3'b011;
                4'b1010: begin alu_op = 3'b001; nz_only = 1'b0; cmp = 1'b1; end
                default: nop = 1'b1;
            endcase
        end
    end

    always_comb begin
        unique case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign flag_we = ((state == EXECUTER) || (state == EXECUTEI)) && cond_ex && (s_bit || cmp) && !nop;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flag_we) begin
            flags[3:2] <= ctl.ALUFlags[3:2];
            if (!nz_only) flags[1:0] <= ctl.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        unique case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                unique case (op)
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    2'b11:   state_nxt = FPU_EN ? FPUEXEC : FETCH;
                    default: state_nxt = i_bit ? EXECUTEI : EXECUTER;
                endcase
            end
            MEMADR:   state_nxt = l_bit ? MEMRD : MEMWR;
            MEMRD:    state_nxt = MEMWB;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            FPUEXEC:  state_nxt = FPUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    always_comb begin
        ctl.PCWrite    = 1'b0;
        ctl.MemWrite   = 1'b0;
        ctl.RegWrite   = 1'b0;
        ctl.IRWrite    = 1'b0;
        ctl.AdrSrc     = 1'b0;
        ctl.ALUSrcA    = 2'b00;
        ctl.ALUSrcB    = 2'b00;
        ctl.ResultSrc  = 2'b00;
        ctl.ALUControl = 3'b000;
        ctl.lmulFlag   = 1'b0;
        ctl.FpuWrite   = 1'b0;
        ctl.RegSrc     = {(op == 2'b01) && !l_bit, op == 2'b10};
        ctl.ImmSrc     = op;
        unique case (state)
            FETCH: begin
                ctl.IRWrite   = 1'b1;
                ctl.PCWrite   = 1'b1;
                ctl.ALUSrcA   = 2'b01;
                ctl.ALUSrcB   = 2'b10;
                ctl.ResultSrc = 2'b10;
            end
            DECODE: begin
                ctl.ALUSrcA   = 2'b01;
                ctl.ALUSrcB   = 2'b10;
                ctl.ResultSrc = 2'b10;
            end
            MEMADR: ctl.ALUSrcB = 2'b01;
            MEMRD:  ctl.AdrSrc = 1'b1;
            MEMWB: begin
                ctl.ResultSrc = 2'b01;
                ctl.RegWrite  = cond_ex;
            end
            MEMWR: begin
                ctl.AdrSrc   = 1'b1;
                ctl.MemWrite = cond_ex;
            end
            EXECUTER: ctl.ALUControl = alu_op;
            EXECUTEI: begin
                ctl.ALUSrcB    = 2'b01;
                ctl.ALUControl = alu_op;
            end
            ALUWB: begin
                ctl.ALUControl = alu_op;
                ctl.RegWrite   = cond_ex && !cmp && !nop;
                ctl.lmulFlag   = is_lmul;
                ctl.PCWrite    = cond_ex && (rd == 4'd15) && !cmp;
            end
            BRANCH: begin
                ctl.ALUSrcB   = 2'b01;
                ctl.ResultSrc = 2'b10;
                ctl.PCWrite   = cond_ex;
            end
            FPUWB:   ctl.FpuWrite = cond_ex;
            default: ;
        endcase
        // Reset must gate every architectural write even mid-instruction.
        if (reset) begin
            ctl.PCWrite  = 1'b0;
            ctl.IRWrite  = 1'b0;
            ctl.MemWrite = 1'b0;
            ctl.RegWrite = 1'b0;
            ctl.FpuWrite = 1'b0;
            ctl.lmulFlag = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against a per-instruction
// phase-table reference model with its own NZCV tracking.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller #(.FPU_EN(1'b1)) dut (.clk(clk), .reset(reset), .ctl(bus.master));

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] mflags = 4'b0000;

    localparam int K_DP = 0, K_LDR = 1, K_STR = 2, K_BR = 3, K_FPU = 4;

    typedef struct {
        int         kind;
        logic [2:0] alu;
        bit         nop;
        bit         cmp;
        int         fmode;   // 0 none, 1 NZ, 2 NZCV
        bit         lmul;
    } dec_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic dec_t decode(logic [31:0] i);
        dec_t d;
        d.kind = K_DP; d.alu = 3'd0; d.nop = 0; d.cmp = 0; d.fmode = 1; d.lmul = 0;
        case (i[27:26])
            2'd1: d.kind = i[20] ? K_LDR : K_STR;
            2'd2: d.kind = K_BR;
            2'd3: d.kind = K_FPU;
            default: begin
                if (i[7:4] == 4'd9 && i[27:22] == 6'd0) d.alu = 3'd4;
                else if (i[7:4] == 4'd9 && i[27:23] == 5'd1) begin
                    d.alu = i[22] ? 3'd6 : 3'd5; d.lmul = 1;
                end else begin
                    case (i[24:21])
                        4'd4:  begin d.alu = 3'd0; d.fmode = 2; end
                        4'd2:  begin d.alu = 3'd1; d.fmode = 2; end
                        4'd0:  d.alu = 3'd2;
                        4'd12: d.alu = 3'd3;
                        4'd10: begin d.alu = 3'd1; d.fmode = 2; d.cmp = 1; end
                        default: begin d.nop = 1; d.fmode = 0; end
                    endcase
                end
            end
        endcase
        return d;
    endfunction

    function automatic int latency(logic [31:0] i);
        dec_t d = decode(i);
        case (d.kind)
            K_LDR: return 5;
            K_BR:  return 3;
            default: return 4;
        endcase
    endfunction

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl,lmulFlag,FpuWrite}
    function automatic logic [19:0] expected(logic [31:0] i, int ph, logic [3:0] f, bit rst);
        dec_t d = decode(i);
        bit pcw = 0, mw = 0, rw = 0, irw = 0, adr = 0, lm = 0, fw = 0, ce;
        logic [1:0] regsrc, asa = 0, asb = 0, rs = 0, imm;
        logic [2:0] alu = 0;
        ce = cond_ok(i[31:28], f);
        regsrc = {d.kind == K_STR, d.kind == K_BR};
        imm = i[27:26];
        if (ph == 0) begin irw = 1; pcw = 1; asa = 1; asb = 2; rs = 2; end
        else if (ph == 1) begin asa = 1; asb = 2; rs = 2; end
        else case (d.kind)
            K_DP: if (ph == 2) begin asb = i[25] ? 2'd1 : 2'd0; alu = d.alu; end
                  else begin
                      alu = d.alu; rw = ce && !d.cmp && !d.nop; lm = d.lmul;
                      pcw = ce && (i[15:12] == 4'd15) && !d.cmp;
                  end
            K_LDR: if (ph == 2) asb = 1; else if (ph == 3) adr = 1; else begin rs = 1; rw = ce; end
            K_STR: if (ph == 2) asb = 1; else begin adr = 1; mw = ce; end
            K_BR:  begin asb = 1; rs = 2; pcw = ce; end
            default: if (ph == 3) fw = ce;
        endcase
        if (rst) begin pcw = 0; mw = 0; rw = 0; irw = 0; lm = 0; fw = 0; end
        return {pcw, mw, rw, irw, adr, regsrc, asa, asb, rs, imm, alu, lm, fw};
    endfunction

    function automatic logic [19:0] observed();
        return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.RegSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl,
                bus.lmulFlag, bus.FpuWrite};
    endfunction

    // Runs one instruction from FETCH; fl<0 picks random ALUFlags each cycle,
    // rst_ph asserts reset during that phase and abandons the instruction.
    task automatic run_instr(input string name, input logic [31:0] i, input int fl, input int rst_ph);
        dec_t d = decode(i);
        int lat = latency(i);
        for (int ph = 0; ph < lat; ph++) begin
            bus.Instr    = i;
            bus.ALUFlags = (fl < 0) ? 4'($urandom) : 4'(fl);
            reset        = (ph == rst_ph);
            @(negedge clk);
            chk($sformatf("%s[%h].p%0d", name, i, ph), 32'(observed()), 32'(expected(i, ph, mflags, reset)));
            if (reset) mflags = 4'b0000;
            else if (d.kind == K_DP && ph == 2 && cond_ok(i[31:28], mflags) && (i[20] || d.cmp) && !d.nop) begin
                mflags[3:2] = bus.ALUFlags[3:2];
                if (d.fmode == 2) mflags[1:0] = bus.ALUFlags[1:0];
            end
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
                break;
            end
        end
        reset = 1'b0;
    endtask

    function automatic logic [3:0] pick_cmd();
        case ($urandom % 6)
            0: return 4'd4;
            1: return 4'd2;
            2: return 4'd0;
            3: return 4'd12;
            4: return 4'd10;
            default: return 4'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i = $urandom;
        case ($urandom % 7)
            0: begin i[27:25] = 3'b001; i[24:21] = pick_cmd(); i[4] = 1'b0; end
            1: begin i[27:25] = 3'b000; i[24:21] = pick_cmd(); i[4] = 1'b0; end
            2: begin i[27:22] = 6'd0; i[7:4] = 4'd9; end
            3: begin i[27:23] = 5'd1; i[7:4] = 4'd9; end
            4: i[27:26] = 2'd1;
            5: i[27:26] = 2'd2;
            default: i[27:26] = 2'd3;
        endcase
        if ($urandom % 8 == 0) i[15:12] = 4'd15;
        return i;
    endfunction

    initial begin
        reset = 1'b1;
        bus.Instr = 32'h0;
        bus.ALUFlags = 4'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_state", 32'(observed()), 32'(expected(32'h0, 0, 4'h0, 1'b1)));
        @(posedge clk); #1;
        reset = 1'b0;
        mflags = 4'b0000;

        run_instr("add_imm", 32'hE2821005, -1, -1);
        run_instr("ldr",     32'hE5910004, -1, -1);
        run_instr("str",     32'hE5810004, -1, -1);
        run_instr("subs",    32'hE2533001, 4, -1);
        chk("flags_after_subs", 32'(mflags), 32'h4);
        run_instr("beq",     32'h0A000002, -1, -1);
        run_instr("bne",     32'h1A000002, -1, -1);
        run_instr("umull",   32'hE0854392, -1, -1);
        run_instr("smull",   32'hE0C54392, -1, -1);
        run_instr("fpu",     32'hEC012100, -1, -1);
        run_instr("fpu_nv",  32'hFC012100, -1, -1);
        run_instr("subs_z",  32'hE2533001, 4, -1);
        run_instr("str_rst", 32'hE5810004, -1, 3);
        run_instr("addeq",   32'h02821005, -1, -1);
        run_instr("cmp_z",   32'hE3530000, 4, -1);
        run_instr("addeq_t", 32'h02821005, -1, -1);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] i = rand_instr();
            int rp = ($urandom % 20 == 0) ? int'($urandom % latency(i)) : -1;
            run_instr($sformatf("rnd%0d", n), i, -1, rp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
